// File: rtl/prv664_scoreboard_if.sv
// prv664_scoreboard_if: dispatch, source-query and commit signals of the register busy table.
interface prv664_scoreboard_if #(parameter int TAG_WIDTH = 4);
    logic                 flush_i;
    logic                 disp0_valid, disp1_valid;
    logic [4:0]           disp0_rdindex, disp1_rdindex;
    logic [TAG_WIDTH-1:0] disp0_tag, disp1_tag;
    logic [4:0]           port0_rs1index, port0_rs2index, port1_rs1index, port1_rs2index;
    logic                 port0_rs1busy, port0_rs2busy, port1_rs1busy, port1_rs2busy;
    logic [TAG_WIDTH-1:0] port0_rs1tag, port0_rs2tag, port1_rs1tag, port1_rs2tag;
    logic                 cmt0_valid, cmt1_valid;
    logic [4:0]           cmt0_rdindex, cmt1_rdindex;
    logic [TAG_WIDTH-1:0] cmt0_tag, cmt1_tag;
    logic                 idle_o;
    modport master (
        output flush_i, disp0_valid, disp1_valid, disp0_rdindex, disp1_rdindex, disp0_tag, disp1_tag,
        output port0_rs1index, port0_rs2index, port1_rs1index, port1_rs2index,
        output cmt0_valid, cmt1_valid, cmt0_rdindex, cmt1_rdindex, cmt0_tag, cmt1_tag,
        input  port0_rs1busy, port0_rs2busy, port1_rs1busy, port1_rs2busy,
        input  port0_rs1tag, port0_rs2tag, port1_rs1tag, port1_rs2tag, idle_o
    );
    modport slave (
        input  flush_i, disp0_valid, disp1_valid, disp0_rdindex, disp1_rdindex, disp0_tag, disp1_tag,
        input  port0_rs1index, port0_rs2index, port1_rs1index, port1_rs2index,
        input  cmt0_valid, cmt1_valid, cmt0_rdindex, cmt1_rdindex, cmt0_tag, cmt1_tag,
        output port0_rs1busy, port0_rs2busy, port1_rs1busy, port1_rs2busy,
        output port0_rs1tag, port0_rs2tag, port1_rs1tag, port1_rs2tag, idle_o
    );
endinterface

// File: rtl/prv664_scoreboard.sv
// prv664_scoreboard: per-register busy/ROB-tag table for dual-issue dispatch with two commit ports.
module prv664_scoreboard #(
    parameter int TAG_WIDTH = 4
) (
    input logic                clk_i,
    input logic                srst_i,
    prv664_scoreboard_if.slave sb
);
    logic [31:0]          busy;
    logic [TAG_WIDTH-1:0] tag [32];
    logic                 byp1, byp2;

    // x0 is skipped so it stays not-busy with tag 0 after reset
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            busy <= '0;
            for (int r = 0; r < 32; r++) tag[r] <= '0;
        end else if (sb.flush_i) begin
            busy <= '0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (sb.disp1_valid && sb.disp1_rdindex == 5'(r)) begin
                    busy[r] <= 1'b1;
                    tag[r]  <= sb.disp1_tag;
                end else if (sb.disp0_valid && sb.disp0_rdindex == 5'(r)) begin
                    busy[r] <= 1'b1;
                    tag[r]  <= sb.disp0_tag;
                end else if ((sb.cmt0_valid && sb.cmt0_rdindex == 5'(r) && sb.cmt0_tag == tag[r]) ||
                             (sb.cmt1_valid && sb.cmt1_rdindex == 5'(r) && sb.cmt1_tag == tag[r])) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

    // slot 1 sources see the older slot 0 writer dispatched in the same cycle
    assign byp1 = sb.disp0_valid && sb.disp0_rdindex != 5'd0 && sb.disp0_rdindex == sb.port1_rs1index;
    assign byp2 = sb.disp0_valid && sb.disp0_rdindex != 5'd0 && sb.disp0_rdindex == sb.port1_rs2index;

    assign sb.port0_rs1busy = busy[sb.port0_rs1index];
    assign sb.port0_rs1tag  = tag[sb.port0_rs1index];
    assign sb.port0_rs2busy = busy[sb.port0_rs2index];
    assign sb.port0_rs2tag  = tag[sb.port0_rs2index];
    assign sb.port1_rs1busy = byp1 | busy[sb.port1_rs1index];
    assign sb.port1_rs1tag  = byp1 ? sb.disp0_tag : tag[sb.port1_rs1index];
    assign sb.port1_rs2busy = byp2 | busy[sb.port1_rs2index];
    assign sb.port1_rs2tag  = byp2 ? sb.disp0_tag : tag[sb.port1_rs2index];
    assign sb.idle_o        = ~|busy;
endmodule

// File: tb/tb_prv664_scoreboard.sv
// tb_prv664_scoreboard: directed and randomized checks of the busy table against a table model.
module tb_prv664_scoreboard;
    localparam int TW = 4;
    logic clk_i = 1'b0;
    logic srst_i;
    int vectors = 0;
    int errors = 0;
    bit m_busy [32];
    logic [TW-1:0] m_tag [32];

    always #5 clk_i = ~clk_i;

    prv664_scoreboard_if #(.TAG_WIDTH(TW)) sb ();
    prv664_scoreboard #(.TAG_WIDTH(TW)) dut (.clk_i(clk_i), .srst_i(srst_i), .sb(sb));

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        sb.flush_i = 0;
        sb.disp0_valid = 0; sb.disp0_rdindex = 0; sb.disp0_tag = 0;
        sb.disp1_valid = 0; sb.disp1_rdindex = 0; sb.disp1_tag = 0;
        sb.cmt0_valid = 0;  sb.cmt0_rdindex = 0;  sb.cmt0_tag = 0;
        sb.cmt1_valid = 0;  sb.cmt1_rdindex = 0;  sb.cmt1_tag = 0;
    endtask

    task automatic set_queries(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c, input logic [4:0] d);
        sb.port0_rs1index = a; sb.port0_rs2index = b; sb.port1_rs1index = c; sb.port1_rs2index = d;
    endtask

    // expected {busy, tag} for a source; slot 1 sources see a same-cycle slot 0 writer
    function automatic logic [TW:0] model_q(input bit slot1, input logic [4:0] idx);
        if (slot1 && sb.disp0_valid && sb.disp0_rdindex != 0 && sb.disp0_rdindex == idx) return {1'b1, sb.disp0_tag};
        if (idx == 0) return '0;
        return {m_busy[idx], m_tag[idx]};
    endfunction

    function automatic bit model_idle();
        for (int r = 0; r < 32; r++) if (m_busy[r]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_queries();
        #1;
        chk("p0rs1", {sb.port0_rs1busy, sb.port0_rs1tag}, model_q(0, sb.port0_rs1index));
        chk("p0rs2", {sb.port0_rs2busy, sb.port0_rs2tag}, model_q(0, sb.port0_rs2index));
        chk("p1rs1", {sb.port1_rs1busy, sb.port1_rs1tag}, model_q(1, sb.port1_rs1index));
        chk("p1rs2", {sb.port1_rs2busy, sb.port1_rs2tag}, model_q(1, sb.port1_rs2index));
        chk("idle", sb.idle_o, model_idle());
    endtask

    // advance one edge and apply the table rules to the model
    task automatic clock();
        @(posedge clk_i);
        if (srst_i) begin
            for (int r = 0; r < 32; r++) begin m_busy[r] = 0; m_tag[r] = 0; end
        end else if (sb.flush_i) begin
            for (int r = 0; r < 32; r++) m_busy[r] = 0;
        end else begin
            if (sb.cmt0_valid && sb.cmt0_rdindex != 0 && m_tag[sb.cmt0_rdindex] == sb.cmt0_tag) m_busy[sb.cmt0_rdindex] = 0;
            if (sb.cmt1_valid && sb.cmt1_rdindex != 0 && m_tag[sb.cmt1_rdindex] == sb.cmt1_tag) m_busy[sb.cmt1_rdindex] = 0;
            if (sb.disp0_valid && sb.disp0_rdindex != 0) begin m_busy[sb.disp0_rdindex] = 1; m_tag[sb.disp0_rdindex] = sb.disp0_tag; end
            if (sb.disp1_valid && sb.disp1_rdindex != 0) begin m_busy[sb.disp1_rdindex] = 1; m_tag[sb.disp1_rdindex] = sb.disp1_tag; end
        end
        #1;
    endtask

    initial begin
        clear_inputs();
        set_queries(5, 5, 5, 5);
        srst_i = 1;
        clock();
        clock();
        srst_i = 0;
        #1;
        chk("rst_busy", {sb.port0_rs1busy, sb.port0_rs2busy, sb.port1_rs1busy, sb.port1_rs2busy}, 0);
        chk("rst_tag", {sb.port0_rs1tag, sb.port0_rs2tag, sb.port1_rs1tag, sb.port1_rs2tag}, 0);
        chk("rst_idle", sb.idle_o, 1);
        check_queries();
        sb.disp0_valid = 1; sb.disp0_rdindex = 5; sb.disp0_tag = 3;
        clock();
        clear_inputs();
        #1;
        chk("x5_busy", {sb.port0_rs1busy, sb.port0_rs1tag}, {1'b1, 4'd3});
        chk("x5_idle", sb.idle_o, 0);
        sb.cmt0_valid = 1; sb.cmt0_rdindex = 5; sb.cmt0_tag = 3;
        clock();
        clear_inputs();
        #1;
        chk("x5_cmt_busy", sb.port0_rs1busy, 0);
        chk("x5_cmt_idle", sb.idle_o, 1);
        sb.disp0_valid = 1; sb.disp0_rdindex = 7; sb.disp0_tag = 2;
        sb.disp1_valid = 1; sb.disp1_rdindex = 7; sb.disp1_tag = 5;
        clock();
        clear_inputs();
        set_queries(7, 7, 7, 7);
        #1;
        chk("x7_disp1_wins", {sb.port0_rs2busy, sb.port0_rs2tag}, {1'b1, 4'd5});
        sb.cmt0_valid = 1; sb.cmt0_rdindex = 7; sb.cmt0_tag = 2;
        clock();
        clear_inputs();
        #1;
        chk("x7_stale_cmt", {sb.port0_rs1busy, sb.port0_rs1tag}, {1'b1, 4'd5});
        check_queries();
        sb.disp0_valid = 1; sb.disp0_rdindex = 9; sb.disp0_tag = 4;
        set_queries(9, 0, 0, 9);
        #1;
        chk("x9_bypass", {sb.port1_rs2busy, sb.port1_rs2tag}, {1'b1, 4'd4});
        chk("x9_no_slot0_byp", sb.port0_rs1busy, 0);
        check_queries();
        clock();
        clear_inputs();
        sb.disp0_valid = 1; sb.disp0_rdindex = 3; sb.disp0_tag = 1;
        clock();
        clear_inputs();
        sb.cmt1_valid = 1; sb.cmt1_rdindex = 3; sb.cmt1_tag = 1;
        sb.disp0_valid = 1; sb.disp0_rdindex = 3; sb.disp0_tag = 6;
        clock();
        clear_inputs();
        set_queries(3, 3, 3, 3);
        #1;
        chk("x3_disp_beats_cmt", {sb.port1_rs1busy, sb.port1_rs1tag}, {1'b1, 4'd6});
        for (int i = 10; i < 18; i++) begin
            sb.disp0_valid = 1; sb.disp0_rdindex = 5'(i); sb.disp0_tag = 4'(i);
            clock();
        end
        clear_inputs();
        sb.flush_i = 1; sb.disp1_valid = 1; sb.disp1_rdindex = 4; sb.disp1_tag = 7;
        set_queries(10, 4, 17, 9);
        #1;
        chk("flush_cycle_busy", sb.port0_rs1busy, 1);
        check_queries();
        clock();
        clear_inputs();
        set_queries(4, 10, 7, 9);
        #1;
        chk("flush_x4", sb.port0_rs1busy, 0);
        chk("flush_idle", sb.idle_o, 1);
        chk("flush_tag_kept", sb.port0_rs2tag, 10);
        check_queries();
        sb.disp0_valid = 1; sb.disp0_rdindex = 0; sb.disp0_tag = 9;
        sb.disp1_valid = 1; sb.disp1_rdindex = 0; sb.disp1_tag = 8;
        set_queries(0, 0, 0, 0);
        #1;
        chk("x0_byp", {sb.port1_rs1busy, sb.port1_rs1tag}, 0);
        clock();
        clear_inputs();
        #1;
        chk("x0_busy", {sb.port0_rs1busy, sb.port0_rs1tag}, 0);
        chk("x0_idle", sb.idle_o, 1);
        sb.disp0_valid = 1; sb.disp0_rdindex = 12; sb.disp0_tag = 11;
        clock();
        srst_i = 1;
        clock();
        srst_i = 0;
        clear_inputs();
        set_queries(12, 0, 0, 0);
        #1;
        chk("midrst", {sb.port0_rs1busy, sb.port0_rs1tag, sb.idle_o}, {1'b0, 4'd0, 1'b1});
        for (int n = 0; n < 500; n++) begin
            srst_i = ($urandom_range(0, 63) == 0);
            sb.flush_i = ($urandom_range(0, 15) == 0);
            sb.disp0_valid = $urandom_range(0, 1); sb.disp0_rdindex = 5'($urandom_range(0, 7)); sb.disp0_tag = 4'($urandom);
            sb.disp1_valid = $urandom_range(0, 1); sb.disp1_rdindex = 5'($urandom_range(0, 7)); sb.disp1_tag = 4'($urandom);
            sb.cmt0_valid = $urandom_range(0, 1); sb.cmt0_rdindex = 5'($urandom_range(0, 7));
            sb.cmt0_tag = $urandom_range(0, 1) ? m_tag[sb.cmt0_rdindex] : 4'($urandom);
            sb.cmt1_valid = $urandom_range(0, 1); sb.cmt1_rdindex = 5'($urandom_range(0, 7));
            sb.cmt1_tag = $urandom_range(0, 1) ? m_tag[sb.cmt1_rdindex] : 4'($urandom);
            set_queries(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            check_queries();
            clock();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
